// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simon_pkg
// Description : Shared types and constants for the Simon sequence controller:
//               FSM state encoding, result codes for the ready/set/go display,
//               LFSR seed and the LFSR next-value function.
// Revision    : 1.0 - initial release
// ============================================================================
package simon_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_SHOW_ON  = 3'd2,
    S_SHOW_OFF = 3'd3,
    S_INPUT    = 3'd4,
    S_PASS     = 3'd5,
    S_FAIL     = 3'd6,
    S_WIN      = 3'd7
  } state_t;

  // Result codes shown on the ready/set/go display
  localparam logic [1:0] c_none = 2'b00;
  localparam logic [1:0] c_pass = 2'b01;
  localparam logic [1:0] c_fail = 2'b10;
  localparam logic [1:0] c_win  = 2'b11;

  localparam logic [7:0] c_lfsr_seed = 8'h01;

  // Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (maximal length,
  // so a non-zero seed can never reach the all-zero lock-up state).
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// ============================================================================
// Module      : lfsr8
// Description : Free-running 8-bit Fibonacci LFSR, steps every clock cycle.
//               Source of the random pattern elements.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset (loads the seed)
//               q     - current LFSR value, never zero
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
  import simon_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= c_lfsr_seed;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/simon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : simon_seq_ctrl
// Description : Simon-game sequence controller. Grows a random pattern by one
//               element per round, shows it, then checks the player's presses
//               against it with a per-press timeout. All outputs registered.
// Ports       : clk        - system clock
//               reset      - asynchronous active-high reset
//               tick       - one-cycle timebase pulse; all durations in ticks
//               start      - level, starts a game from IDLE/FAIL/WIN
//               btn_valid  - one-cycle button press strobe
//               btn_code   - pressed button index 0..3
//               show_valid - a pattern element is being displayed
//               show_code  - displayed element (0 when not displaying)
//               correct    - 00 none, 01 pass, 10 fail, 11 win
//               score      - rounds completed in the current game
//               busy       - high outside IDLE/FAIL/WIN
// Revision    : 1.0 - initial release
// ============================================================================
module simon_seq_ctrl
  import simon_pkg::*;
#(
  parameter int SEQ_MAX       = 16,
  parameter int ON_TICKS      = 4,
  parameter int OFF_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 20,
  parameter int RESULT_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_code,
  output logic       show_valid,
  output logic [1:0] show_code,
  output logic [1:0] correct,
  output logic [4:0] score,
  output logic       busy
);

  // Pattern index width; the store is rounded up to a power of two so the
  // index slice always covers the whole array.
  localparam int c_idx_w = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

  localparam logic [4:0] c_seq_max  = 5'(SEQ_MAX);
  localparam logic [4:0] c_on_last  = 5'(ON_TICKS - 1);
  localparam logic [4:0] c_off_last = 5'(OFF_TICKS - 1);
  localparam logic [4:0] c_to_last  = 5'(TIMEOUT_TICKS - 1);
  localparam logic [4:0] c_res_last = 5'(RESULT_TICKS - 1);

  state_t               r_state;
  logic [4:0]           r_len;
  logic [4:0]           r_idx;
  logic [4:0]           r_score;
  logic [4:0]           r_tcnt;
  logic                 r_show_valid;
  logic [1:0]           r_show_code;
  logic [1:0]           r_correct;
  logic                 r_busy;
  logic [1:0]           r_pattern [2**c_idx_w];

  logic [7:0]           w_lfsr;
  logic [c_idx_w-1:0]   w_idx_nxt;
  logic                 w_unused_lfsr;

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  assign w_idx_nxt     = r_idx[c_idx_w-1:0] + c_idx_w'(1);
  assign w_unused_lfsr = ^w_lfsr[7:2];

  // Pattern store has no reset: every entry is written by ADD before it is
  // ever shown or compared.
  always_ff @(posedge clk) begin
    if (r_state == S_ADD) begin
      r_pattern[r_len[c_idx_w-1:0]] <= w_lfsr[1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= 5'd0;
      r_idx        <= 5'd0;
      r_score      <= 5'd0;
      r_tcnt       <= 5'd0;
      r_show_valid <= 1'b0;
      r_show_code  <= 2'd0;
      r_correct    <= c_none;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_FAIL, S_WIN: begin
          if (start) begin
            r_len     <= 5'd0;
            r_score   <= 5'd0;
            r_idx     <= 5'd0;
            r_tcnt    <= 5'd0;
            r_correct <= c_none;
            r_busy    <= 1'b1;
            r_state   <= S_ADD;
          end
        end

        S_ADD: begin
          if (r_len < c_seq_max) begin
            r_len <= r_len + 5'd1;
          end
          r_idx        <= 5'd0;
          r_tcnt       <= 5'd0;
          r_show_valid <= 1'b1;
          // In round one element 0 is being written this very cycle, so
          // forward it straight from the LFSR.
          r_show_code  <= (r_len == 5'd0) ? w_lfsr[1:0] : r_pattern[{c_idx_w{1'b0}}];
          r_state      <= S_SHOW_ON;
        end

        S_SHOW_ON: begin
          if (tick) begin
            if (r_tcnt == c_on_last) begin
              r_tcnt       <= 5'd0;
              r_show_valid <= 1'b0;
              r_show_code  <= 2'd0;
              r_state      <= S_SHOW_OFF;
            end else begin
              r_tcnt <= r_tcnt + 5'd1;
            end
          end
        end

        S_SHOW_OFF: begin
          if (tick) begin
            if (r_tcnt == c_off_last) begin
              r_tcnt <= 5'd0;
              if (r_idx + 5'd1 < r_len) begin
                r_idx        <= r_idx + 5'd1;
                r_show_valid <= 1'b1;
                r_show_code  <= r_pattern[w_idx_nxt];
                r_state      <= S_SHOW_ON;
              end else begin
                r_idx   <= 5'd0;
                r_state <= S_INPUT;
              end
            end else begin
              r_tcnt <= r_tcnt + 5'd1;
            end
          end
        end

        S_INPUT: begin
          // A press wins over a coincident final timeout tick.
          if (btn_valid) begin
            r_tcnt <= 5'd0;
            if (btn_code == r_pattern[r_idx[c_idx_w-1:0]]) begin
              if (r_idx == r_len - 5'd1) begin
                if (r_score < c_seq_max) begin
                  r_score <= r_score + 5'd1;
                end
                r_correct <= c_pass;
                r_state   <= S_PASS;
              end else begin
                r_idx <= r_idx + 5'd1;
              end
            end else begin
              r_correct <= c_fail;
              r_busy    <= 1'b0;
              r_state   <= S_FAIL;
            end
          end else if (tick) begin
            if (r_tcnt == c_to_last) begin
              r_tcnt    <= 5'd0;
              r_correct <= c_fail;
              r_busy    <= 1'b0;
              r_state   <= S_FAIL;
            end else begin
              r_tcnt <= r_tcnt + 5'd1;
            end
          end
        end

        S_PASS: begin
          if (tick) begin
            if (r_tcnt == c_res_last) begin
              r_tcnt <= 5'd0;
              if (r_len < c_seq_max) begin
                r_correct <= c_none;
                r_state   <= S_ADD;
              end else begin
                r_correct <= c_win;
                r_busy    <= 1'b0;
                r_state   <= S_WIN;
              end
            end else begin
              r_tcnt <= r_tcnt + 5'd1;
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign show_valid = r_show_valid;
  assign show_code  = r_show_code;
  assign correct    = r_correct;
  assign score      = r_score;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_simon_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_simon_seq_ctrl
// Description : Self-checking bench for simon_seq_ctrl. Two instances share
//               clock/reset/tick: u_dut (SEQ_MAX=16) and u_dut_win
//               (SEQ_MAX=2); sel picks which one receives start/btn and is
//               observed. Expected values come from the game rules: a model
//               LFSR, a queue of expected pattern elements and tick counting.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simon_seq_ctrl;

  localparam int ON_T  = 4;
  localparam int OFF_T = 2;
  localparam int TO_T  = 20;
  localparam int RES_T = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic       sel;

  logic       sv_a, sv_b, busy_a, busy_b;
  logic [1:0] sc_a, sc_b, cor_a, cor_b;
  logic [4:0] score_a, score_b;

  logic       show_valid_m, busy_m;
  logic [1:0] show_code_m, correct_m;
  logic [4:0] score_m;

  assign show_valid_m = sel ? sv_b    : sv_a;
  assign show_code_m  = sel ? sc_b    : sc_a;
  assign correct_m    = sel ? cor_b   : cor_a;
  assign score_m      = sel ? score_b : score_a;
  assign busy_m       = sel ? busy_b  : busy_a;

  simon_seq_ctrl #(
    .SEQ_MAX(16), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
    .TIMEOUT_TICKS(TO_T), .RESULT_TICKS(RES_T)
  ) u_dut (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start & ~sel), .btn_valid(btn_valid & ~sel), .btn_code(btn_code),
    .show_valid(sv_a), .show_code(sc_a), .correct(cor_a),
    .score(score_a), .busy(busy_a)
  );

  simon_seq_ctrl #(
    .SEQ_MAX(2), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T),
    .TIMEOUT_TICKS(TO_T), .RESULT_TICKS(RES_T)
  ) u_dut_win (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start & sel), .btn_valid(btn_valid & sel), .btn_code(btn_code),
    .show_valid(sv_b), .show_code(sc_b), .correct(cor_b),
    .score(score_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seed 1, one step per clock.
  logic [7:0] m_lfsr;
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'h01;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_pat [$];
  int         exp_score;
  int         cur_max;

  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic noise();
    return ($urandom_range(0, 3) == 0);
  endfunction
  function automatic logic [1:0] rcode();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic cyc(input logic t, input logic bv, input logic [1:0] bc, input logic st);
    tick = t; btn_valid = bv; btn_code = bc; start = st;
    @(posedge clk);
    #1;
    tick = 1'b0; btn_valid = 1'b0; btn_code = 2'd0; start = 1'b0;
  endtask

  task automatic start_game(input string tag);
    cyc(coin(), coin(), rcode(), 1'b1);
    checks++;
    if (busy_m !== 1'b1 || correct_m !== 2'b00 || score_m !== 5'd0 || show_valid_m !== 1'b0) begin
      errors++;
      $display("FAIL %s_add: busy=%0b correct=%b score=%0d show=%0b, want 1/00/0/0",
               tag, busy_m, correct_m, score_m, show_valid_m);
    end
    exp_pat.delete();
    exp_pat.push_back(m_lfsr[1:0]);
    exp_score = 0;
    cyc(coin(), 1'b0, 2'd0, 1'b0);
  endtask

  task automatic show_phase(input string tag);
    int   n;
    int   g;
    logic t;
    for (int e = 0; e < exp_pat.size(); e++) begin
      checks++;
      if (show_valid_m !== 1'b1 || show_code_m !== exp_pat[e]) begin
        errors++;
        $display("FAIL %s_on_entry e=%0d: show=%0b code=%0d, want 1/%0d",
                 tag, e, show_valid_m, show_code_m, exp_pat[e]);
      end
      n = 0; g = 0;
      while (n < ON_T) begin
        t = (g > 40) ? 1'b1 : coin();
        g++;
        cyc(t, noise(), rcode(), 1'b0);
        if (t) n++;
        if (n < ON_T) begin
          checks++;
          if (show_valid_m !== 1'b1 || show_code_m !== exp_pat[e] || busy_m !== 1'b1) begin
            errors++;
            $display("FAIL %s_on_hold e=%0d ticks=%0d: show=%0b code=%0d, want 1/%0d",
                     tag, e, n, show_valid_m, show_code_m, exp_pat[e]);
          end
        end
      end
      checks++;
      if (show_valid_m !== 1'b0 || show_code_m !== 2'd0) begin
        errors++;
        $display("FAIL %s_off_entry e=%0d: show=%0b code=%0d, want 0/0",
                 tag, e, show_valid_m, show_code_m);
      end
      n = 0; g = 0;
      while (n < OFF_T) begin
        t = (g > 40) ? 1'b1 : coin();
        g++;
        cyc(t, noise(), rcode(), 1'b0);
        if (t) n++;
        if (n < OFF_T) begin
          checks++;
          if (show_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL %s_off_hold e=%0d: show=%0b, want 0", tag, e, show_valid_m);
          end
        end
      end
    end
    checks++;
    if (show_valid_m !== 1'b0 || busy_m !== 1'b1 || correct_m !== 2'b00) begin
      errors++;
      $display("FAIL %s_input_entry: show=%0b busy=%0b correct=%b, want 0/1/00",
               tag, show_valid_m, busy_m, correct_m);
    end
  endtask

  // Wait 'pre' tick pulses in INPUT without pressing, then press 'code'.
  task automatic press(input logic [1:0] code, input int pre, input logic t_on_press);
    int   n = 0;
    int   g = 0;
    logic t;
    while (n < pre) begin
      t = (g > 60) ? 1'b1 : coin();
      g++;
      cyc(t, 1'b0, 2'd0, 1'b0);
      if (t) n++;
      checks++;
      if (busy_m !== 1'b1 || correct_m !== 2'b00) begin
        errors++;
        $display("FAIL input_wait ticks=%0d: busy=%0b correct=%b, want 1/00",
                 n, busy_m, correct_m);
      end
    end
    cyc(t_on_press, 1'b1, code, 1'b0);
  endtask

  task automatic play_inputs(input string tag);
    for (int i = 0; i < exp_pat.size(); i++) begin
      press(exp_pat[i], $urandom_range(0, TO_T - 1), coin());
      if (i < exp_pat.size() - 1) begin
        checks++;
        if (busy_m !== 1'b1 || correct_m !== 2'b00) begin
          errors++;
          $display("FAIL %s_mid_press i=%0d: busy=%0b correct=%b, want 1/00",
                   tag, i, busy_m, correct_m);
        end
      end
    end
  endtask

  // Entered right after the final correct press.
  task automatic pass_phase(input string tag);
    int   n = 0;
    int   g = 0;
    logic t;
    if (exp_score < cur_max) exp_score++;
    checks++;
    if (correct_m !== 2'b01 || score_m !== 5'(exp_score) || busy_m !== 1'b1) begin
      errors++;
      $display("FAIL %s_pass_entry: correct=%b score=%0d busy=%0b, want 01/%0d/1",
               tag, correct_m, score_m, busy_m, exp_score);
    end
    while (n < RES_T) begin
      t = (g > 40) ? 1'b1 : coin();
      g++;
      cyc(t, noise(), rcode(), 1'b0);
      if (t) n++;
      if (n < RES_T) begin
        checks++;
        if (correct_m !== 2'b01) begin
          errors++;
          $display("FAIL %s_pass_hold: correct=%b, want 01", tag, correct_m);
        end
      end
    end
    if (exp_pat.size() < cur_max) begin
      checks++;
      if (correct_m !== 2'b00 || busy_m !== 1'b1 || show_valid_m !== 1'b0 ||
          score_m !== 5'(exp_score)) begin
        errors++;
        $display("FAIL %s_next_add: correct=%b busy=%0b show=%0b score=%0d, want 00/1/0/%0d",
                 tag, correct_m, busy_m, show_valid_m, score_m, exp_score);
      end
      exp_pat.push_back(m_lfsr[1:0]);
      cyc(coin(), 1'b0, 2'd0, 1'b0);
    end else begin
      checks++;
      if (correct_m !== 2'b11 || busy_m !== 1'b0 || score_m !== 5'(exp_score)) begin
        errors++;
        $display("FAIL %s_win_entry: correct=%b busy=%0b score=%0d, want 11/0/%0d",
                 tag, correct_m, busy_m, score_m, exp_score);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tick = 1'b0; start = 1'b0; btn_valid = 1'b0; btn_code = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (show_valid_m !== 1'b0 || show_code_m !== 2'd0 || correct_m !== 2'b00 ||
        score_m !== 5'd0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: show=%0b code=%0d correct=%b score=%0d busy=%0b, want all 0",
               show_valid_m, show_code_m, correct_m, score_m, busy_m);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(coin(), coin(), rcode(), 1'b0);
      checks++;
      if (busy_m !== 1'b0 || correct_m !== 2'b00 || show_valid_m !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: busy=%0b correct=%b show=%0b, want 0/00/0",
                 busy_m, correct_m, show_valid_m);
      end
    end
  endtask

  task automatic test_show_first();
    logic [7:0] nx;
    nx = lfsr_next(m_lfsr);
    for (int g = 0; g < 300 && nx[1:0] != 2'd2; g++) begin
      cyc(coin(), 1'b0, 2'd0, 1'b0);
      nx = lfsr_next(m_lfsr);
    end
    start_game("first");
    checks++;
    if (show_code_m !== 2'd2) begin
      errors++;
      $display("FAIL first_code: show_code=%0d, want 2", show_code_m);
    end
    show_phase("first");
  endtask

  task automatic test_pass_round();
    play_inputs("r1");
    pass_phase("r1");
    show_phase("r2");
  endtask

  task automatic test_fail_wrong();
    press(2'd1, $urandom_range(0, TO_T - 1), coin());
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (correct_m !== 2'b10 || busy_m !== 1'b0 || score_m !== 5'd1 || show_valid_m !== 1'b0) begin
        errors++;
        $display("FAIL wrong_hold i=%0d: correct=%b busy=%0b score=%0d, want 10/0/1",
                 i, correct_m, busy_m, score_m);
      end
      cyc(coin(), coin(), rcode(), 1'b0);
    end
    start_game("restart");
    show_phase("restart");
  endtask

  task automatic test_timeout();
    int   n = 0;
    int   g = 0;
    logic t;
    press(exp_pat[0], TO_T - 1, 1'b1);
    pass_phase("to_edge");
    show_phase("to_r2");
    press(exp_pat[0], $urandom_range(0, TO_T - 1), coin());
    checks++;
    if (busy_m !== 1'b1 || correct_m !== 2'b00) begin
      errors++;
      $display("FAIL to_first_press: busy=%0b correct=%b, want 1/00", busy_m, correct_m);
    end
    while (n < TO_T) begin
      t = (g > 80) ? 1'b1 : coin();
      g++;
      cyc(t, 1'b0, 2'd0, 1'b0);
      if (t) n++;
      if (n < TO_T) begin
        checks++;
        if (busy_m !== 1'b1 || correct_m !== 2'b00) begin
          errors++;
          $display("FAIL to_wait ticks=%0d: busy=%0b correct=%b, want 1/00",
                   n, busy_m, correct_m);
        end
      end
    end
    checks++;
    if (correct_m !== 2'b10 || busy_m !== 1'b0 || score_m !== 5'd1) begin
      errors++;
      $display("FAIL to_expire: correct=%b busy=%0b score=%0d, want 10/0/1",
               correct_m, busy_m, score_m);
    end
  endtask

  task automatic test_random_game();
    int         rounds;
    int         k;
    logic [1:0] bad;
    start_game("rnd");
    show_phase("rnd");
    rounds = $urandom_range(2, 5);
    for (int r = 0; r < rounds; r++) begin
      play_inputs("rnd");
      pass_phase("rnd");
      show_phase("rnd");
    end
    k = $urandom_range(0, exp_pat.size() - 1);
    for (int i = 0; i < k; i++) press(exp_pat[i], $urandom_range(0, TO_T - 1), coin());
    bad = exp_pat[k] ^ 2'($urandom_range(1, 3));
    press(bad, $urandom_range(0, TO_T - 1), coin());
    checks++;
    if (correct_m !== 2'b10 || busy_m !== 1'b0 || score_m !== 5'(exp_score)) begin
      errors++;
      $display("FAIL rnd_wrong k=%0d: correct=%b busy=%0b score=%0d, want 10/0/%0d",
               k, correct_m, busy_m, score_m, exp_score);
    end
  endtask

  task automatic test_reset_mid();
    start_game("rst");
    show_phase("rst");
    play_inputs("rst");
    pass_phase("rst");
    cyc(1'b0, 1'b0, 2'd0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (show_valid_m !== 1'b0 || correct_m !== 2'b00 || score_m !== 5'd0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: show=%0b correct=%b score=%0d busy=%0b, want 0/00/0/0",
               show_valid_m, correct_m, score_m, busy_m);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    cyc(coin(), coin(), rcode(), 1'b0);
    checks++;
    if (show_valid_m !== 1'b0 || correct_m !== 2'b00 || score_m !== 5'd0 || busy_m !== 1'b0) begin
      errors++;
      $display("FAIL reset_after: show=%0b correct=%b score=%0d busy=%0b, want 0/00/0/0",
               show_valid_m, correct_m, score_m, busy_m);
    end
  endtask

  task automatic test_win();
    sel = 1'b1;
    cur_max = 2;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    start_game("win");
    show_phase("win_r1");
    play_inputs("win_r1");
    pass_phase("win_r1");
    show_phase("win_r2");
    play_inputs("win_r2");
    pass_phase("win_r2");
    for (int i = 0; i < 8; i++) begin
      cyc(coin(), 1'b1, rcode(), 1'b0);
      checks++;
      if (correct_m !== 2'b11 || score_m !== 5'd2 || busy_m !== 1'b0 || show_valid_m !== 1'b0) begin
        errors++;
        $display("FAIL win_hold i=%0d: correct=%b score=%0d busy=%0b show=%0b, want 11/2/0/0",
                 i, correct_m, score_m, busy_m, show_valid_m);
      end
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0;
    cur_max = 16;
    exp_score = 0;
    test_reset();
    test_show_first();
    test_pass_round();
    test_fail_wrong();
    test_timeout();
    test_random_game();
    test_reset_mid();
    test_win();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/simon_seq_ctrl.md
SIMON_SEQ_CTRL -- requirements
Module: simon_seq_ctrl

Interface
REQ-001 Parameter SEQ_MAX, default 16: maximum sequence length; a round at this length that is passed ends the game as a win.
REQ-002 Parameter ON_TICKS, default 4: ticks each pattern element is shown.
REQ-003 Parameter OFF_TICKS, default 2: blank ticks between shown elements.
REQ-004 Parameter TIMEOUT_TICKS, default 20: ticks allowed per player press before FAIL.
REQ-005 Parameter RESULT_TICKS, default 3: ticks PASS is held before the next round.
REQ-006 clk  input  1  system clock; single clock domain.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 tick  input  1  one-cycle enable pulse from the clock divider; all tick counts are measured in these pulses.
REQ-009 start  input  1  level; sampled only in IDLE, FAIL or WIN.
REQ-010 btn_valid  input  1  one-cycle pulse; the player pressed a button.
REQ-011 btn_code  input  2  button index 0..3; valid only with btn_valid.
REQ-012 show_valid  output  1  high while a pattern element is displayed.
REQ-013 show_code  output  2  element being displayed; 0 when show_valid is low.
REQ-014 correct  output  2  result code to the ready/set/go display: 00 none, 01 pass, 10 fail, 11 win.
REQ-015 score  output  5  rounds completed in the current game, 0..SEQ_MAX.
REQ-016 busy  output  1  high in every state except IDLE, FAIL and WIN.

Function
REQ-017 The FSM states SHALL be IDLE, ADD, SHOW_ON, SHOW_OFF, INPUT, PASS, FAIL and WIN.
REQ-018 An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'h01) SHALL step every clk cycle, including while idle, and SHALL never reach the value 0.
REQ-019 In IDLE, FAIL or WIN, start=1 SHALL clear len, score and idx and enter ADD on the next clock.
REQ-020 ADD SHALL last exactly one cycle: it writes lfsr[1:0] into pattern[len], increments len, clears idx, zeroes the tick counter and enters SHOW_ON.
REQ-021 SHOW_ON SHALL drive show_valid=1 and show_code=pattern[idx] for ON_TICKS ticks, then enter SHOW_OFF.
REQ-022 SHOW_OFF SHALL last OFF_TICKS ticks; it then increments idx and returns to SHOW_ON if idx+1<len; otherwise it clears idx and enters INPUT.
REQ-023 In INPUT, btn_valid with btn_code==pattern[idx] SHALL reset the timeout counter and increment idx; when idx reaches len-1 it SHALL instead increment score and enter PASS.
REQ-024 In INPUT, btn_valid with a mismatching code SHALL enter FAIL on the next clock.
REQ-025 In INPUT, TIMEOUT_TICKS ticks without btn_valid SHALL enter FAIL.
REQ-026 If btn_valid and the final timeout tick occur in the same cycle, the button SHALL take priority.
REQ-027 btn_valid outside INPUT SHALL be ignored.
REQ-028 PASS SHALL drive correct=01 for RESULT_TICKS ticks, then enter ADD if len<SEQ_MAX, otherwise WIN.
REQ-029 FAIL SHALL drive correct=10 and WIN SHALL drive correct=11; both hold until start=1; correct SHALL be 00 in all other states.
REQ-030 All outputs SHALL be registered (Moore); a state change is visible one cycle after the causing input.
REQ-031 The tick counter SHALL be 5 bits, cleared on every state entry, and SHALL count only tick pulses.
REQ-032 score and len SHALL saturate at SEQ_MAX and never wrap.

Reset
REQ-033 Reset SHALL force IDLE, len=0, idx=0, score=0, show_valid=0, show_code=0, correct=00, busy=0, LFSR=8'h01 and the tick counter to 0, asynchronously and from any state, including mid-round.
REQ-034 Pattern storage SHALL NOT be reset; it is always rewritten by ADD before it is read.

Structure
REQ-035 Package simon_pkg SHALL hold the state enumeration, the correct-code constants (NONE, PASS, FAIL, WIN) and the LFSR seed.
REQ-036 The LFSR SHALL be the sub-module lfsr8 (ports: clk, reset, q[7:0]); the rest is one FSM with a register-array pattern store.

Verification
REQ-037 Reset mid-SHOW_ON -> next cycle state=IDLE, show_valid=0, correct=00, score=0.
REQ-038 start with the LFSR forced to lfsr[1:0]=2 at ADD -> show_code=2 for exactly 4 ticks, then 2 blank ticks, then INPUT.
REQ-039 Round 1 with pattern {2}, btn_code=2 -> correct=01 for 3 ticks, score=1, then round 2 shows 2 elements.
REQ-040 Round 2 with pattern {2,x}, first press 1 -> correct=10, busy=0; holds until start, then score=0.
REQ-041 No press for 20 ticks in INPUT -> FAIL; a correct press landing on tick 20 -> no FAIL.
REQ-042 SEQ_MAX=2, two rounds passed -> correct=11, score=2, WIN held; btn_valid in WIN has no effect.
